// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pll_reset_sequencer
//  Description : PLL lock supervisor and system reset generator. Pulses the
//                PLL reset, filters the asynchronous lock flag and releases the
//                system reset once lock has been stable for STABLE_CYCLES.
//                Optional lock statistics enabled by PLL_LOCK_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT   = 65536
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       running
`ifdef PLL_LOCK_STATS_EN
    ,
    output logic [7:0] loss_count,
    output logic [7:0] timeout_count
`endif
);

    localparam logic [1:0] c_st_pll_reset = 2'd0;
    localparam logic [1:0] c_st_wait_lock = 2'd1;
    localparam logic [1:0] c_st_stabilize = 2'd2;
    localparam logic [1:0] c_st_running   = 2'd3;

    localparam int c_max_ab     = (PLL_RST_CYCLES > STABLE_CYCLES) ? PLL_RST_CYCLES : STABLE_CYCLES;
    localparam int c_max_cycles = (c_max_ab > LOCK_TIMEOUT) ? c_max_ab : LOCK_TIMEOUT;
    localparam int c_cnt_w      = (c_max_cycles > 1) ? $clog2(c_max_cycles) : 1;

    localparam logic [c_cnt_w-1:0] c_rst_last    = c_cnt_w'(PLL_RST_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_stable_last = c_cnt_w'(STABLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_tmo_last    = c_cnt_w'(LOCK_TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one     = c_cnt_w'(1);

    logic               r_sync_meta;
    logic               r_locked_s;
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               r_pll_rst;
    logic               r_sys_reset;
    logic               r_running;
    logic               w_pll_rst_nxt;
    logic               w_sys_reset_nxt;
    logic               w_running_nxt;

    // Two-flop synchronizer for the asynchronous lock flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_meta <= 1'b0;
            r_locked_s  <= 1'b0;
        end else begin
            r_sync_meta <= pll_locked;
            r_locked_s  <= r_sync_meta;
        end
    end

    // State register; outputs are registered from the next state so they
    // change on the same edge as the transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_pll_reset;
            r_cnt       <= '0;
            r_pll_rst   <= 1'b1;
            r_sys_reset <= 1'b1;
            r_running   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pll_rst   <= w_pll_rst_nxt;
            r_sys_reset <= w_sys_reset_nxt;
            r_running   <= w_running_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (relock_req) begin
            w_state_nxt = c_st_pll_reset;
        end else begin
            case (r_state)
                c_st_pll_reset: begin
                    if (r_cnt == c_rst_last) w_state_nxt = c_st_wait_lock;
                    else                     w_cnt_nxt   = r_cnt + c_cnt_one;
                end
                c_st_wait_lock: begin
                    if (r_locked_s)               w_state_nxt = c_st_stabilize;
                    else if (r_cnt == c_tmo_last) w_state_nxt = c_st_pll_reset;
                    else                          w_cnt_nxt   = r_cnt + c_cnt_one;
                end
                c_st_stabilize: begin
                    if (!r_locked_s)                 w_state_nxt = c_st_wait_lock;
                    else if (r_cnt == c_stable_last) w_state_nxt = c_st_running;
                    else                             w_cnt_nxt   = r_cnt + c_cnt_one;
                end
                c_st_running: begin
                    if (!r_locked_s) w_state_nxt = c_st_pll_reset;
                end
                default: begin
                    w_state_nxt = c_st_pll_reset;
                end
            endcase
        end
        // A relock while already pulsing counts as a fresh entry
        if (relock_req || (w_state_nxt != r_state)) begin
            w_cnt_nxt = '0;
        end
    end

    // Output decode from the next state
    always_comb begin
        w_pll_rst_nxt   = (w_state_nxt == c_st_pll_reset);
        w_running_nxt   = (w_state_nxt == c_st_running);
        w_sys_reset_nxt = !w_running_nxt;
    end

    assign pll_rst   = r_pll_rst;
    assign sys_reset = r_sys_reset;
    assign running   = r_running;

`ifdef PLL_LOCK_STATS_EN
    logic       w_loss_evt;
    logic       w_tmo_evt;
    logic [7:0] r_loss_count;
    logic [7:0] r_timeout_count;

    // A coincident relock request suppresses both events
    always_comb begin
        w_loss_evt = !relock_req && (r_state == c_st_running) && !r_locked_s;
        w_tmo_evt  = !relock_req && (r_state == c_st_wait_lock) && !r_locked_s
                     && (r_cnt == c_tmo_last);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_loss_count    <= 8'd0;
            r_timeout_count <= 8'd0;
        end else begin
            if (w_loss_evt && (r_loss_count != 8'hFF)) begin
                r_loss_count <= r_loss_count + 8'd1;
            end
            if (w_tmo_evt && (r_timeout_count != 8'hFF)) begin
                r_timeout_count <= r_timeout_count + 8'd1;
            end
        end
    end

    assign loss_count    = r_loss_count;
    assign timeout_count = r_timeout_count;
`endif

endmodule
`default_nettype wire
